led_pattern_gen: RTL and testbench

- Parametrised, multi-channel successor to the single-LED clock/reset test blinker.
- Drives NUM_CH board LEDs. Each channel has its own mode (OFF/ON/BLINK/PWM), period and duty.
- A valid/ready config port reprograms channels at runtime; a sync input phase-aligns all channels.
- Sits at the board top level and is used for clock/reset bring-up and status indication.

---
 rtl/led_pattern_gen.sv | 144 ++++++++++++++
 tb/tb_led_pattern_gen.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: per-channel OFF/ON/BLINK/PWM with runtime
// reprogramming over a valid/ready config port and a global phase-align pulse.
`timescale 1ns/1ps

module led_pattern_gen #(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 32,
    parameter int DEFAULT_PERIOD = 1000,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_duty,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] led,
    output logic [NUM_CH-1:0] wrap
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_t;

    logic cfg_accept;
    logic cfg_ch_ok;

    assign cfg_accept = cfg_valid && cfg_ready;
    assign cfg_ch_ok  = int'(cfg_ch) < NUM_CH;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_ready <= 1'b1;
            cfg_err   <= cfg_accept && !cfg_ch_ok;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        mode_t            mode_q, mode_d;
        logic [CNT_W-1:0] period_q, period_d;
        logic [CNT_W-1:0] duty_q, duty_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             led_q, led_d;
        logic             wrap_q, wrap_d;
        logic [CNT_W-1:0] p_eff;
        logic [CNT_W-1:0] cnt_inc;
        logic             at_end;
        logic             wr_hit;
        logic             counting;

        assign wr_hit   = cfg_accept && cfg_ch_ok && (int'(cfg_ch) == i);
        assign counting = (mode_q == MODE_BLINK) || (mode_q == MODE_PWM);

        // A programmed period of zero behaves as one, so the counter stays at 0
        // and wraps on every enabled cycle.
        assign p_eff   = (period_q == '0) ? CNT_W'(1) : period_q;
        assign at_end  = (cnt_q == p_eff - CNT_W'(1));
        assign cnt_inc = at_end ? '0 : cnt_q + CNT_W'(1);

        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        always_comb begin
            mode_d   = mode_q;
            period_d = period_q;
            duty_d   = duty_q;
            cnt_d    = cnt_q;
            led_d    = led_q;
            wrap_d   = 1'b0;

            if (wr_hit) begin
                mode_d   = mode_t'(cfg_mode);
                period_d = cfg_period;
                duty_d   = cfg_duty;
                cnt_d    = '0;
                led_d    = (mode_t'(cfg_mode) == MODE_ON);
            end else if (sync && counting) begin
                cnt_d = '0;
                led_d = (mode_q == MODE_PWM) && (duty_q != '0);
            end else if (enable) begin
                unique case (mode_q)
                    MODE_OFF: begin
                        cnt_d = '0;
                        led_d = 1'b0;
                    end
                    MODE_ON: begin
                        cnt_d = '0;
                        led_d = 1'b1;
                    end
                    MODE_BLINK: begin
                        cnt_d  = cnt_inc;
                        wrap_d = at_end;
                        led_d  = led_q ^ at_end;
                    end
                    MODE_PWM: begin
                        cnt_d  = cnt_inc;
                        wrap_d = at_end;
                        led_d  = (cnt_inc < duty_q);
                    end
                    default: begin
                        cnt_d = '0;
                        led_d = 1'b0;
                    end
                endcase
            end
        end

        // NOTE: these per-channel registers are few and drive visible outputs,
        // so all of them are reset rather than left to power-up values.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mode_q   <= MODE_OFF;
                period_q <= CNT_W'(DEFAULT_PERIOD);
                duty_q   <= '0;
                cnt_q    <= '0;
                led_q    <= 1'b0;
                wrap_q   <= 1'b0;
            end else begin
                mode_q   <= mode_d;
                period_q <= period_d;
                duty_q   <= duty_d;
                cnt_q    <= cnt_d;
                led_q    <= led_d;
                wrap_q   <= wrap_d;
            end
        end

        assign led[i]  = led_q;
        assign wrap[i] = wrap_q;
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: a cycle model of the channel rules pushes
// expected outputs per edge; a negedge monitor pops and compares them.
`timescale 1ns/1ps

module tb_led_pattern_gen;

    localparam int NUM_CH = 5;
    localparam int CNT_W  = 16;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              clk;
    logic              rst;
    logic              enable;
    logic              sync;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [1:0]        cfg_mode;
    logic [CNT_W-1:0]  cfg_period;
    logic [CNT_W-1:0]  cfg_duty;
    logic              cfg_err;
    logic [NUM_CH-1:0] led;
    logic [NUM_CH-1:0] wrap;

    led_pattern_gen #(
        .NUM_CH(NUM_CH),
        .CNT_W(CNT_W),
        .DEFAULT_PERIOD(1000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .sync(sync),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode),
        .cfg_period(cfg_period),
        .cfg_duty(cfg_duty),
        .cfg_err(cfg_err),
        .led(led),
        .wrap(wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: effective period, counter phase and LED per channel.
    typedef struct {
        logic [NUM_CH-1:0] led;
        logic [NUM_CH-1:0] wrap;
        logic              err;
        logic              ready;
    } exp_t;

    exp_t   exp_q[$];
    int     m_mode [NUM_CH];
    longint m_p    [NUM_CH];
    longint m_duty [NUM_CH];
    longint m_cnt  [NUM_CH];
    bit     m_led  [NUM_CH];
    bit     m_ready;

    function automatic void model_reset();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_mode[ch] = 0;
            m_p[ch]    = 1000;
            m_duty[ch] = 0;
            m_cnt[ch]  = 0;
            m_led[ch]  = 1'b0;
        end
        m_ready = 1'b0;
    endfunction

    function automatic void model_edge();
        exp_t e;
        bit   acc;
        e.wrap = '0;
        e.err  = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            acc = cfg_valid && m_ready;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (acc && int'(cfg_ch) == ch) begin
                    m_mode[ch] = int'(cfg_mode);
                    m_p[ch]    = (cfg_period == 0) ? 1 : longint'(cfg_period);
                    m_duty[ch] = longint'(cfg_duty);
                    m_cnt[ch]  = 0;
                    m_led[ch]  = (cfg_mode == 2'd1);
                end else if (sync && m_mode[ch] >= 2) begin
                    m_cnt[ch] = 0;
                    m_led[ch] = (m_mode[ch] == 3) && (m_duty[ch] > 0);
                end else if (enable) begin
                    if (m_mode[ch] < 2) begin
                        m_cnt[ch] = 0;
                        m_led[ch] = (m_mode[ch] == 1);
                    end else begin
                        m_cnt[ch] = (m_cnt[ch] + 1) % m_p[ch];
                        if (m_cnt[ch] == 0) begin
                            e.wrap[ch] = 1'b1;
                            if (m_mode[ch] == 2) m_led[ch] = !m_led[ch];
                        end
                        if (m_mode[ch] == 3) m_led[ch] = (m_cnt[ch] < m_duty[ch]);
                    end
                end
            end
            e.err   = acc && (int'(cfg_ch) >= NUM_CH);
            m_ready = 1'b1;
        end
        for (int ch = 0; ch < NUM_CH; ch++) e.led[ch] = m_led[ch];
        e.ready = m_ready;
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_led", 32'(led), 32'(e.led));
            check("sb_wrap", 32'(wrap), 32'(e.wrap));
            check("sb_cfg_err", 32'(cfg_err), 32'(e.err));
            check("sb_cfg_ready", 32'(cfg_ready), 32'(e.ready));
        end
    end

    // Each tick: model the edge, then return 1ns after the falling edge to drive.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input int ch, input int mode, input int period, input int duty);
        cfg_valid  = 1'b1;
        cfg_ch     = CH_W'(ch);
        cfg_mode   = 2'(mode);
        cfg_period = CNT_W'(period);
        cfg_duty   = CNT_W'(duty);
        tick(1);
        cfg_valid  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0]       pat_led;
        logic [15:0]       pat_wrap;
        logic [NUM_CH-1:0] held;
        int                cnt;

        rst = 1'b1; enable = 1'b0; sync = 1'b0; cfg_valid = 1'b0;
        cfg_ch = '0; cfg_mode = '0; cfg_period = '0; cfg_duty = '0;
        model_reset();

        tick(2);
        check("reset_led", 32'(led), 32'h0);
        check("reset_ready", 32'(cfg_ready), 32'h0);
        rst = 1'b0;
        enable = 1'b1;
        tick(1);
        check("ready_first_edge", 32'(cfg_ready), 32'h1);
        tick(2000);
        check("idle_led", 32'(led), 32'h0);

        // BLINK P=4 on ch0
        cfg_write(0, 2, 4, 0);
        for (int i = 0; i < 16; i++) begin
            pat_led[15-i]  = led[0];
            pat_wrap[15-i] = wrap[0];
            tick(1);
        end
        check("blink4_pattern", 32'(pat_led), 32'h0F0F);
        check("blink4_wrap", 32'(pat_wrap), 32'h0888);

        // PWM P=10 duty=3, then duty 0 and duty above period
        cfg_write(1, 3, 10, 3);
        tick(1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin cnt += int'(led[1]); tick(1); end
        check("pwm_3_of_10", 32'(cnt), 32'd3);
        cfg_write(1, 3, 10, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin cnt += int'(led[1]); tick(1); end
        check("pwm_duty0", 32'(cnt), 32'd0);
        cfg_write(1, 3, 10, 12);
        tick(1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin cnt += int'(led[1]); tick(1); end
        check("pwm_duty_full", 32'(cnt), 32'd20);

        // sync with ch0 P=4 and ch2 P=6 mid-count
        cfg_write(2, 2, 6, 0);
        tick(5);
        sync = 1'b1;
        tick(1);
        sync = 1'b0;
        check("sync_led0", 32'(led[0]), 32'h0);
        check("sync_led2", 32'(led[2]), 32'h0);
        tick(3);
        check("sync_wrap0_early", 32'(wrap[0]), 32'h0);
        tick(1);
        check("sync_wrap0", 32'(wrap[0]), 32'h1);
        check("sync_wrap2_early", 32'(wrap[2]), 32'h0);
        tick(2);
        check("sync_wrap2", 32'(wrap[2]), 32'h1);

        // out-of-range channel, then period 0
        held = led;
        cfg_write(NUM_CH, 1, 3, 3);
        check("bad_ch_err", 32'(cfg_err), 32'h1);
        tick(1);
        check("bad_ch_err_pulse", 32'(cfg_err), 32'h0);
        check("bad_ch_led3", 32'(led[3]), 32'(held[3]));
        cfg_write(3, 2, 0, 0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin tick(1); cnt += int'(wrap[3]); end
        check("period0_wraps", 32'(cnt), 32'd8);

        // freeze mid-blink
        tick(2);
        held = led;
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("freeze_led", 32'(led), 32'(held));
            check("freeze_wrap", 32'(wrap), 32'h0);
        end
        enable = 1'b1;
        tick(30);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            cfg_valid  = ($urandom_range(0, 7) == 0);
            cfg_ch     = CH_W'($urandom_range(0, 7));
            cfg_mode   = 2'($urandom_range(0, 3));
            cfg_period = CNT_W'($urandom_range(0, 12));
            cfg_duty   = CNT_W'($urandom_range(0, 14));
            sync       = ($urandom_range(0, 40) == 0);
            enable     = ($urandom_range(0, 9) != 0);
            tick(1);
        end
        cfg_valid = 1'b0; sync = 1'b0; enable = 1'b1;
        tick(5);

        // asynchronous reset mid-run
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_led", 32'(led), 32'h0);
        check("async_rst_wrap", 32'(wrap), 32'h0);
        check("async_rst_ready", 32'(cfg_ready), 32'h0);
        tick(2);
        rst = 1'b0;
        tick(1);
        check("post_rst_ready", 32'(cfg_ready), 32'h1);
        tick(50);
        check("post_rst_all_off", 32'(led), 32'h0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
